// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : axi_read_arbiter
//  Brief   : Round-robin arbiter sharing one AXI burst-read master between
//            the noise-estimation reader (0) and the Wiener-filter reader (1).
//            Latches the winner's command, issues it as one start_read pulse
//            and steers returning beats to the owner until rlast.
//  Rev     : 1.0  initial release
// ============================================================================
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // requester 0
  input  logic                  req0_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [31:0]           req0_len_i,
  input  logic [2:0]            req0_size_i,
  input  logic [1:0]            req0_burst_i,
  output logic                  gnt0_o,
  output logic                  rvalid0_o,
  output logic                  rlast0_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic                  done0_o,
  // requester 1
  input  logic                  req1_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [31:0]           req1_len_i,
  input  logic [2:0]            req1_size_i,
  input  logic [1:0]            req1_burst_i,
  output logic                  gnt1_o,
  output logic                  rvalid1_o,
  output logic                  rlast1_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic                  done1_o,
  // command side towards the AXI master
  output logic                  start_read_o,
  output logic [ADDR_WIDTH-1:0] read_addr_o,
  output logic [31:0]           read_len_o,
  output logic [2:0]            read_size_o,
  output logic [1:0]            read_burst_o,
  // read-data channel, observed only
  input  logic                  rvalid_i,
  input  logic                  rready_i,
  input  logic                  rlast_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  // status
  output logic                  busy_o,
  output logic [15:0]           beat_cnt_o,
  output logic                  stray_beat_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    owner_q;       // 1: requester 1 owns the bus
  logic                    last_grant_q;  // requester granted most recently
  logic [ADDR_WIDTH-1:0]   read_addr_q;
  logic [31:0]             read_len_q;
  logic [2:0]              read_size_q;
  logic [1:0]              read_burst_q;
  logic                    gnt0_q;
  logic                    gnt1_q;
  logic                    start_read_q;
  logic                    done0_q;
  logic                    done1_q;
  logic                    busy_q;
  logic                    stray_q;
  logic [15:0]             beat_cnt_q;
  logic [15:0]             beat_cnt_d;

  logic                    w_beat;
  logic                    w_any_req;
  logic                    w_pick;        // 1: requester 1 wins this IDLE cycle
  logic                    w_route;
  logic                    w_route0;
  logic                    w_route1;

  assign w_beat    = rvalid_i & rready_i;
  assign w_any_req = req0_i | req1_i;

  // Saturating beat counter next value
  assign beat_cnt_d = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;

  // Round-robin pick: on a tie the requester not granted last wins
  always_comb begin
    w_pick = 1'b0;
    if (req0_i && req1_i) begin
      w_pick = ~last_grant_q;
    end else if (req1_i) begin
      w_pick = 1'b1;
    end
  end

  // Arbitration FSM with registered command, grant, done and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      read_addr_q  <= '0;
      read_len_q   <= '0;
      read_size_q  <= '0;
      read_burst_q <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      start_read_q <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
      stray_q      <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      start_read_q <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;

      // A beat with no burst in flight is never routed; remember it
      if (w_beat && (state_q != WAIT_DATA)) begin
        stray_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (w_any_req) begin
            owner_q      <= w_pick;
            read_addr_q  <= w_pick ? req1_addr_i  : req0_addr_i;
            read_len_q   <= w_pick ? req1_len_i   : req0_len_i;
            read_size_q  <= w_pick ? req1_size_i  : req0_size_i;
            read_burst_q <= w_pick ? req1_burst_i : req0_burst_i;
            start_read_q <= 1'b1;
            gnt0_q       <= ~w_pick;
            gnt1_q       <= w_pick;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          beat_cnt_q <= '0;
          state_q    <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (w_beat) begin
            beat_cnt_q <= beat_cnt_d;
            if (rlast_i) begin
              last_grant_q <= owner_q;
              done0_q      <= ~owner_q;
              done1_q      <= owner_q;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Zero-latency steering of read beats to the current owner only
  assign w_route  = (state_q == WAIT_DATA) & w_beat;
  assign w_route0 = w_route & ~owner_q;
  assign w_route1 = w_route &  owner_q;

  assign rvalid0_o = w_route0;
  assign rlast0_o  = w_route0 & rlast_i;
  assign rdata0_o  = w_route0 ? rdata_i : '0;
  assign rvalid1_o = w_route1;
  assign rlast1_o  = w_route1 & rlast_i;
  assign rdata1_o  = w_route1 ? rdata_i : '0;

  assign gnt0_o       = gnt0_q;
  assign gnt1_o       = gnt1_q;
  assign done0_o      = done0_q;
  assign done1_o      = done1_q;
  assign start_read_o = start_read_q;
  assign read_addr_o  = read_addr_q;
  assign read_len_o   = read_len_q;
  assign read_size_o  = read_size_q;
  assign read_burst_o = read_burst_q;
  assign busy_o       = busy_q;
  assign beat_cnt_o   = beat_cnt_q;
  assign stray_beat_o = stray_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_axi_read_arbiter
//  Brief   : Self-checking bench for axi_read_arbiter. Randomised read-data
//            handshakes are checked against a transaction-level model of the
//            round-robin grant order, command timing and beat routing.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_axi_read_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 40;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0  = 1'b0;
  logic          req1  = 1'b0;
  logic [AW-1:0] f_addr  [2];
  logic [31:0]   f_len   [2];
  logic [2:0]    f_size  [2];
  logic [1:0]    f_burst [2];
  logic          rvalid = 1'b0;
  logic          rready = 1'b0;
  logic          rlast  = 1'b0;
  logic [DW-1:0] rdata  = '0;

  logic          gnt0, gnt1, rvalid0, rvalid1, rlast0, rlast1, done0, done1;
  logic [DW-1:0] rdata0, rdata1;
  logic          start_read, busy, stray;
  logic [AW-1:0] read_addr;
  logic [31:0]   read_len;
  logic [2:0]    read_size;
  logic [1:0]    read_burst;
  logic [15:0]   beat_cnt;

  int n_vec  = 0;
  int n_err  = 0;
  int cyc    = 0;
  int m_last = 1;   // model: requester granted most recently
  int m_free = 0;   // model: cycle in which the arbiter is IDLE again
  int rq_cyc = 0;   // model: cycle in which the pending requests were raised

  axi_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_i       (req0),
    .req0_addr_i  (f_addr[0]),
    .req0_len_i   (f_len[0]),
    .req0_size_i  (f_size[0]),
    .req0_burst_i (f_burst[0]),
    .gnt0_o       (gnt0),
    .rvalid0_o    (rvalid0),
    .rlast0_o     (rlast0),
    .rdata0_o     (rdata0),
    .done0_o      (done0),
    .req1_i       (req1),
    .req1_addr_i  (f_addr[1]),
    .req1_len_i   (f_len[1]),
    .req1_size_i  (f_size[1]),
    .req1_burst_i (f_burst[1]),
    .gnt1_o       (gnt1),
    .rvalid1_o    (rvalid1),
    .rlast1_o     (rlast1),
    .rdata1_o     (rdata1),
    .done1_o      (done1),
    .start_read_o (start_read),
    .read_addr_o  (read_addr),
    .read_len_o   (read_len),
    .read_size_o  (read_size),
    .read_burst_o (read_burst),
    .rvalid_i     (rvalid),
    .rready_i     (rready),
    .rlast_i      (rlast),
    .rdata_i      (rdata),
    .busy_o       (busy),
    .beat_cnt_o   (beat_cnt),
    .stray_beat_o (stray)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // Inputs change just after the falling edge; outputs are sampled 1 unit later
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic bus_idle();
    rvalid = 1'b0;
    rready = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic set_fields(input int i, input logic [AW-1:0] a, input logic [31:0] l);
    f_addr[i]  = a;
    f_len[i]   = l;
    f_size[i]  = 3'($urandom_range(0, 7));
    f_burst[i] = 2'($urandom_range(0, 3));
  endtask

  // Round-robin rule: a lone request wins; on a tie the one not granted last
  function automatic int pick(input logic r0, input logic r1, input int last);
    if (r0 && r1) return (last == 1) ? 0 : 1;
    return r1 ? 1 : 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    bus_idle();
    repeat (3) step();
    rst_n  = 1'b1;
    m_last = 1;
    m_free = cyc;
  endtask

  // One full transaction: grant, command, randomised beats, done pulse
  task automatic txn(input int nbeats, input bit fixed, input logic [DW-1:0] fdata);
    int w, sel, guard, k;
    logic beat, ov, ol, xv, xl;
    logic [DW-1:0] od, xd;
    logic [15:0] cnt;
    w     = pick(req0, req1, m_last);
    sel   = (rq_cyc > m_free) ? rq_cyc : m_free;
    guard = 0;
    do begin
      step();
      bus_idle();
      #1;
      guard++;
      if (!start_read) begin
        n_vec++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
          n_err++;
          $display("FAIL pre_grant: gnt0=%b gnt1=%b busy=%b at cycle %0d, required 0/0/0", gnt0, gnt1, busy, cyc);
        end
      end
    end while (!start_read && guard < TMO);
    n_vec++;
    if (start_read !== 1'b1 || cyc != sel + 1) begin
      n_err++;
      $display("FAIL start_timing: start_read=%b at cycle %0d, required 1 at cycle %0d", start_read, cyc, sel + 1);
    end
    if (start_read !== 1'b1) return;
    n_vec++;
    if ({gnt0, gnt1} !== ((w == 0) ? 2'b10 : 2'b01) || read_addr !== f_addr[w] ||
        read_len !== f_len[w] || read_size !== f_size[w] || read_burst !== f_burst[w] || busy !== 1'b1) begin
      n_err++;
      $display("FAIL command: gnt0/1=%b%b addr=%h len=%h size=%0d burst=%0d busy=%b, required gnt to %0d addr=%h len=%h size=%0d burst=%0d busy=1",
               gnt0, gnt1, read_addr, read_len, read_size, read_burst, busy, w, f_addr[w], f_len[w], f_size[w], f_burst[w]);
    end
    if (w == 0) req0 = 1'b0; else req1 = 1'b0;

    k = 0; cnt = '0; guard = 0;
    while (k < nbeats && guard < 400) begin
      step();
      guard++;
      rvalid = ($urandom_range(0, 3) != 0);
      rready = ($urandom_range(0, 3) != 0);
      rdata  = fixed ? fdata : DW'($urandom);
      rlast  = rvalid && (k == nbeats - 1);
      #1;
      beat = rvalid && rready;
      ov = (w == 0) ? rvalid0 : rvalid1;
      ol = (w == 0) ? rlast0  : rlast1;
      od = (w == 0) ? rdata0  : rdata1;
      xv = (w == 0) ? rvalid1 : rvalid0;
      xl = (w == 0) ? rlast1  : rlast0;
      xd = (w == 0) ? rdata1  : rdata0;
      n_vec++;
      if (ov !== beat || (beat && (ol !== rlast || od !== rdata)) || {xv, xl} !== 2'b00 || xd !== '0 ||
          beat_cnt !== cnt || {start_read, gnt0, gnt1, done0, done1, busy} !== 6'b000001) begin
        n_err++;
        $display("FAIL beat%0d: own v/l/d=%b/%b/%h other v/l/d=%b/%b/%h cnt=%0d ctl=%b, required own v=%b l=%b d=%h other 0/0/0 cnt=%0d ctl=000001",
                 k, ov, ol, od, xv, xl, xd, beat_cnt, {start_read, gnt0, gnt1, done0, done1, busy}, beat, rlast, rdata, cnt);
      end
      if (beat) begin
        k++;
        if (cnt != 16'hFFFF) cnt++;
      end
    end
    step();
    bus_idle();
    #1;
    n_vec++;
    if ({done0, done1} !== ((w == 0) ? 2'b10 : 2'b01) || beat_cnt !== cnt || busy !== 1'b0 || start_read !== 1'b0) begin
      n_err++;
      $display("FAIL done: done0/1=%b%b beat_cnt=%0d busy=%b start=%b, required done to %0d beat_cnt=%0d busy=0 start=0",
               done0, done1, beat_cnt, busy, start_read, w, cnt);
    end
    m_free = cyc;
    m_last = w;
  endtask

  task automatic test_reset();
    req0 = 1'b1; req1 = 1'b1;
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; rdata = DW'($urandom);
    repeat (2) step();
    #1;
    n_vec++;
    if ({gnt0, gnt1, start_read, done0, done1, busy, stray} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctl: gnt/start/done/busy/stray=%b, required 0000000", {gnt0, gnt1, start_read, done0, done1, busy, stray});
    end
    n_vec++;
    if (read_addr !== '0 || read_len !== '0 || read_size !== '0 || read_burst !== '0 || beat_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_cmd: addr=%h len=%h size=%0d burst=%0d cnt=%0d, required all 0", read_addr, read_len, read_size, read_burst, beat_cnt);
    end
    n_vec++;
    if ({rvalid0, rvalid1, rlast0, rlast1} !== 4'b0 || rdata0 !== '0 || rdata1 !== '0) begin
      n_err++;
      $display("FAIL reset_route: v/l=%b d0=%h d1=%h, required 0", {rvalid0, rvalid1, rlast0, rlast1}, rdata0, rdata1);
    end
    do_reset();
  endtask

  task automatic test_single();
    set_fields(0, 32'h40, 32'd16);
    req0 = 1'b1; rq_cyc = cyc;
    txn(16, 1'b0, '0);
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_fields(0, 32'h200, 32'd3);
    set_fields(1, 32'h100, 32'd5);
    req0 = 1'b1; req1 = 1'b1; rq_cyc = cyc;
    txn(3, 1'b0, '0);
    txn(5, 1'b0, '0);
  endtask

  task automatic test_contention();
    set_fields(0, 32'h1000, 32'd4);
    set_fields(1, 32'h2000, 32'd4);
    req0 = 1'b1; req1 = 1'b1; rq_cyc = cyc;
    for (int i = 0; i < 4; i++) begin
      txn(4, 1'b0, '0);
      rq_cyc = cyc;
      if (!req0) begin set_fields(0, 32'h1000 + 32'(i) * 32'h40, 32'd4); req0 = 1'b1; end
      if (!req1) begin set_fields(1, 32'h2000 + 32'(i) * 32'h40, 32'd4); req1 = 1'b1; end
    end
    // drain the two requests left pending
    txn(4, 1'b0, '0);
    txn(4, 1'b0, '0);
  endtask

  task automatic test_routing();
    set_fields(1, 32'h3000, 32'd5);
    req1 = 1'b1; rq_cyc = cyc;
    txn(5, 1'b1, 32'hDEADBEEF);
  endtask

  task automatic test_stray();
    step();
    #1;
    n_vec++;
    if (stray !== 1'b0) begin
      n_err++;
      $display("FAIL stray_pre: stray_beat=%b, required 0", stray);
    end
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; rdata = DW'($urandom);
    #1;
    n_vec++;
    if ({rvalid0, rvalid1, rlast0, rlast1} !== 4'b0 || rdata0 !== '0 || rdata1 !== '0) begin
      n_err++;
      $display("FAIL stray_route: v/l=%b d0=%h d1=%h, required 0", {rvalid0, rvalid1, rlast0, rlast1}, rdata0, rdata1);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      bus_idle();
      #1;
      n_vec++;
      if (stray !== 1'b1 || {done0, done1, busy, start_read} !== 4'b0) begin
        n_err++;
        $display("FAIL stray_hold%0d: stray=%b done/busy/start=%b, required 1 and 0000", i, stray, {done0, done1, busy, start_read});
      end
    end
    m_free = cyc;
  endtask

  task automatic test_reset_mid();
    int guard, k;
    set_fields(0, 32'h4000, 32'd8);
    req0 = 1'b1;
    guard = 0;
    do begin step(); #1; guard++; end while (!start_read && guard < TMO);
    n_vec++;
    if (start_read !== 1'b1 || gnt0 !== 1'b1 || read_len !== 32'd8) begin
      n_err++;
      $display("FAIL mid_grant: start=%b gnt0=%b len=%0d, required 1/1/8", start_read, gnt0, read_len);
    end
    req0 = 1'b0;
    k = 0; guard = 0;
    while (k < 3 && guard < TMO) begin
      step();
      guard++;
      rvalid = 1'b1; rready = 1'b1; rlast = 1'b0; rdata = DW'($urandom);
      #1;
      if (rvalid0) k++;
    end
    step();
    rst_n = 1'b0;
    rdata = DW'($urandom);
    #1;
    n_vec++;
    if ({start_read, gnt0, gnt1, busy, done0, done1, stray, rvalid0, rvalid1, rlast0, rlast1} !== 11'b0 ||
        beat_cnt !== '0 || read_addr !== '0 || read_len !== '0 || rdata0 !== '0 || rdata1 !== '0) begin
      n_err++;
      $display("FAIL mid_reset: flags=%b cnt=%0d addr=%h len=%h d0=%h d1=%h, required all 0",
               {start_read, gnt0, gnt1, busy, done0, done1, stray, rvalid0, rvalid1, rlast0, rlast1}, beat_cnt, read_addr, read_len, rdata0, rdata1);
    end
    step();
    step();
    rst_n = 1'b1;
    m_last = 1;
    m_free = cyc;
    step();
    rdata = DW'($urandom);
    rlast = 1'b1;
    #1;
    n_vec++;
    if ({rvalid0, rvalid1, rlast0, rlast1} !== 4'b0) begin
      n_err++;
      $display("FAIL mid_leftover_route: v/l=%b, required 0000", {rvalid0, rvalid1, rlast0, rlast1});
    end
    step();
    bus_idle();
    #1;
    n_vec++;
    if (stray !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_stray: stray=%b busy=%b, required 1/0", stray, busy);
    end
    set_fields(1, 32'h5000, 32'd2);
    req1 = 1'b1; rq_cyc = cyc;
    txn(2, 1'b0, '0);
  endtask

  task automatic test_random();
    int r;
    for (int t = 0; t < 12; t++) begin
      r = $urandom_range(1, 3);
      if (!req0 && r[0]) begin
        set_fields(0, AW'($urandom), ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom)); req0 = 1'b1;
      end
      if (!req1 && r[1]) begin
        set_fields(1, AW'($urandom), ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom)); req1 = 1'b1;
      end
      rq_cyc = cyc;
      txn($urandom_range(1, 6), 1'b0, '0);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      f_addr[i] = '0; f_len[i] = '0; f_size[i] = '0; f_burst[i] = '0;
    end
    test_reset();
    test_single();
    test_simultaneous();
    test_contention();
    test_routing();
    test_stray();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
